serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor that computes A - B - bin one bit per clock, LSB first, using a single registered borrow stage. It is the inverse operation of the team's ripple-carry adder. It is used where area matters more than latency, and it shares the adder's operand format (unsigned or two's complement, 4-bit default). A start/busy/done handshake frames each operation, and the results are held in output registers until the next operation completes.

Parameters:
WIDTH, 4, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock; the only clock
reset  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled on rising edge of clk
A  input  WIDTH  minuend; sampled only on the edge that accepts start
B  input  WIDTH  subtrahend; sampled only on the edge that accepts start
bin  input  1  borrow-in; sampled only on the edge that accepts start
diff  output  WIDTH  registered result, A - B - bin mod 2^WIDTH
borrowout  output  1  registered final borrow; 1 when unsigned A < B + bin
overflow  output  1  registered two's-complement overflow flag
busy  output  1  1 while state is RUN
done  output  1  one-cycle pulse marking new valid results

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Nothing is asynchronous.
- Reset (sampled high on an edge):
  - state goes to IDLE
  - diff = 0, borrowout = 0, overflow = 0, busy = 0, done = 0
  - bit counter, operand shift registers and borrow flop cleared
  - reset wins over start on the same edge
- States:
  - IDLE: busy = 0, done = 0.
    - start = 1 → latch A, B and bin; initialise borrow flop to bin and counter to 0; go to RUN.
  - RUN: busy = 1, done = 0. Each edge processes the current LSB pair (a, b) with borrow br:
    - d = a ^ b ^ br
    - br_next = (~a & b) | (~(a ^ b) & br)
    - d shifts into the MSB of the internal result shift register; both operand registers shift right; counter increments.
    - On the edge that processes bit WIDTH-1, load diff from the completed shift register, borrowout from br_next, and overflow; go to DONE.
  - DONE: done = 1, busy = 0, for exactly one cycle.
    - start = 1 → accept a new operation (same actions as in IDLE) and go to RUN.
    - Otherwise go to IDLE.
- Overflow = (A_lat[WIDTH-1] != B_lat[WIDTH-1]) && (diff_new[WIDTH-1] != A_lat[WIDTH-1]), using the latched operands. bin does not enter the overflow equation beyond its effect on diff.
- Latency: if start is accepted on edge k, diff, borrowout and overflow update and done rises on edge k+WIDTH. done falls on edge k+WIDTH+1.
- Throughput: back-to-back operations every WIDTH+1 cycles, by asserting start during DONE.
- start while in RUN is ignored; there is no queueing. A, B and bin may change freely after the accepting edge.
- diff, borrowout and overflow hold their last values in IDLE, RUN and DONE. They change only on the completion edge or on reset.
- Reset during RUN aborts the operation: no done pulse, results cleared to 0.
- start held high continuously produces an operation every WIDTH+1 cycles.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then start on edge 0 with A=7, B=3, bin=0 → busy=1 on edges 1-3; on edge 4: diff=4, borrowout=0, overflow=0, done=1; done=0 from edge 5.
- A=3, B=7, bin=0 → diff=12, borrowout=1, overflow=0.
- A=8, B=1, bin=0 (signed -8-1) → diff=7, borrowout=0, overflow=1.
- A=0, B=0, bin=1 → diff=15, borrowout=1, overflow=0.
- Start A=9, B=2 accepted; pulse start with A=1, B=1 on edge 2 (during RUN) → ignored, result diff=7. Then assert start during DONE with A=5, B=5 → diff=0 exactly 5 cycles later, with no IDLE cycle in between.
- Start A=6, B=1, then assert reset on edge 2 → diff=0, borrowout=0, overflow=0, busy=0, no done pulse. Next start with A=6, B=1 → diff=5 after 4 edges.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = A - B - bin, one bit per clock, LSB first.
// Start/busy/done handshake; results held in output registers until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             borrowout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic             a_msb, b_msb;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             accept, last, d_bit, br_nx;
    logic [WIDTH-1:0] diff_new;

    // One full-subtractor cell shared by every bit position.
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ br;
        br_nx    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        diff_new = {d_bit, res_sh[WIDTH-1:1]};
        last     = (cnt == LAST_BIT);
        accept   = start && (state != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            br        <= 1'b0;
            cnt       <= '0;
            diff      <= '0;
            borrowout <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            br     <= bin;
            cnt    <= '0;
            res_sh <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= diff_new;
            br     <= br_nx;
            cnt    <= cnt + CW'(1);
            if (last) begin
                diff      <= diff_new;
                borrowout <= br_nx;
                // Signed overflow only possible when operand signs differ.
                overflow  <= (a_msb != b_msb) && (diff_new[WIDTH-1] != a_msb);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
